// File: rtl/shift_arb_pkg.sv
// Shared encodings and helpers for the shift_arb block.
// Holds op/state encodings, the all-ones constant and a bit-reverse helper.
package shift_arb_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_arb_rr_arb2.sv
// rr_arb2: 2-way arbiter, round-robin (ARB_MODE=1) or fixed to port 0.
// Ports: clk, rst, req[1:0], take (grant used this cycle), gnt[1:0].
module rr_arb2 #(
    parameter int ARB_MODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // Port favoured when both request; starts at port 0.
    logic prio;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ARB_MODE != 0 && prio) ? 2'b10 : 2'b01;
        end
    end

    // The port just granted loses the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (take && gnt != 2'b00) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/shift_arb.sv
// shift_arb: two requesters share one 32-bit right shifter (SRL/SLL/SRA).
// Ports: req_valid/ready/a/b/op per port in, resp_valid/ready per port, resp_data shared.
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int ARB_MODE = 1,
    parameter int NPORT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_valid,
    output logic [NPORT-1:0]       req_ready,
    input  logic [NPORT-1:0][31:0] req_a,
    input  logic [NPORT-1:0][31:0] req_b,
    input  logic [NPORT-1:0][1:0]  req_op,
    output logic [NPORT-1:0]       resp_valid,
    input  logic [NPORT-1:0]       resp_ready,
    output logic [31:0]            resp_data
);

    state_e      state;
    state_e      state_nxt;
    logic [1:0]  gnt;
    logic        sel;
    logic        accept;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    op_e         lat_op;
    logic        lat_port;

    logic        big;
    logic [31:0] core_in;
    logic [31:0] core_out;
    logic [31:0] fill;
    logic [31:0] result;

    assign accept = (state == S_IDLE) && (|req_valid) && !rst;
    assign sel    = gnt[1];

    rr_arb2 #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .take (accept),
        .gnt  (gnt)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready = gnt;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid[lat_port] = 1'b1;
                if (resp_ready[lat_port]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Nothing is accepted while reset is being applied.
        if (rst) begin
            req_ready = '0;
        end
    end

    // Shift amounts of 32 or more flush the value entirely.
    assign big = |lat_b[31:5];

    // SLL reuses the right shifter by mirroring input and output.
    assign core_in  = (lat_op == OP_SLL) ? bitrev32(lat_a) : lat_a;
    assign core_out = big ? '0 : (core_in >> lat_b[4:0]);
    assign fill     = big ? ALL_ONES : ~(ALL_ONES >> lat_b[4:0]);

    always_comb begin
        result = core_out;
        case (lat_op)
            OP_SLL:  result = bitrev32(core_out);
            OP_SRA:  result = core_out | (lat_a[31] ? fill : '0);
            default: result = core_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            resp_data <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_op    <= OP_SRL;
            lat_port  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_a    <= req_a[sel];
                lat_b    <= req_b[sel];
                lat_op   <= op_e'(req_op[sel]);
                lat_port <= sel;
            end
            if (state == S_EXEC) begin
                resp_data <= result;
            end
        end
    end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter: ARB_MODE, default 1, meaning 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 Parameter: NPORT, default 2, meaning number of requester ports (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-port request valid.
REQ-006 req_ready  output  2  per-port request accepted this cycle.
REQ-007 req_a  input  2x32  per-port operand (value to shift).
REQ-008 req_b  input  2x32  per-port shift amount (full 32 bits significant).
REQ-009 req_op  input  2x2  per-port op: 00 SRL, 01 SLL, 10 SRA, 11 reserved (treated as SRL).
REQ-010 resp_valid  output  2  per-port result valid.
REQ-011 resp_ready  input  2  per-port result consumed.
REQ-012 resp_data  output  32  result, shared bus, meaningful for the port whose resp_valid is high.

Function
REQ-013 Block SHALL share one 32-bit logical right shifter core among the ports, with at most one operation in flight.
REQ-014 FSM states: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid is high, grant one port, assert its req_ready for exactly that cycle, latch a/b/op/port, and go to EXEC; otherwise stay.
REQ-016 EXEC: drive the shifter from the latched operands, register the result into resp_data, and go to RESP; duration exactly one cycle.
REQ-017 RESP: hold resp_valid[granted port] and resp_data stable until resp_ready[granted port] is high, then go to IDLE.
REQ-018 Latency: resp_valid rises 2 cycles after the accept edge; minimum issue interval is 3 cycles.
REQ-019 req_ready SHALL be 0 in EXEC and RESP; at most one req_ready bit is high per cycle.
REQ-020 Round-robin: on a simultaneous request, the port not granted last wins; after reset, port 0 wins first.
REQ-021 Fixed mode: port 0 always wins a tie.
REQ-022 SRL: result = a >> b, using a zero-fill shift.
REQ-023 SLL: bit-reverse a, shift right by b, bit-reverse the result.
REQ-024 SRA: SRL result OR'd with ~(32'hFFFFFFFF >> b) when a[31]=1.
REQ-025 b >= 32 (any of b[31:5] set): SRL/SLL give 0; SRA gives 32'hFFFFFFFF if a[31]=1, else 0.
REQ-026 b = 0: result = a for all ops.
REQ-027 resp_ready on a non-granted port, or outside RESP, SHALL be ignored.
REQ-028 A request deasserted before it is granted SHALL be dropped without side effects.

Reset
REQ-029 rst high SHALL force IDLE, req_ready=0, resp_valid=0, resp_data=0, and round-robin pointer = port 0 at the next edge.
REQ-030 rst asserted in EXEC or RESP SHALL abort the operation; no resp_valid is produced for it afterward.

Structure
REQ-031 Shared package SHALL hold the op encodings (SRL/SLL/SRA), the state encodings, and the all-ones constant 32'hFFFFFFFF.
REQ-032 One sub-module, rr_arb2 (2-way round-robin/fixed arbiter, grant plus pointer update), SHALL be used.
REQ-033 The shifter core SHALL be instantiated once; bit-reverse and sign-fill logic SHALL wrap it in shift_arb.

Verification
REQ-034 Port 0: a=32'h8000_00F0, b=4, op=SRL -> resp_data=32'h0800_000F, resp_valid[0] rising 2 cycles after accept.
REQ-035 Port 1: a=32'h8000_00F0, b=4, op=SRA -> 32'hF800_000F; then op=SLL -> 32'h0000_0F00.
REQ-036 a=32'h8000_0000, b=32'h0000_0020, op=SRA -> 32'hFFFF_FFFF; same operands with op=SRL -> 0.
REQ-037 Both ports requesting continuously (ARB_MODE=1) -> grants alternate 0,1,0,1; with ARB_MODE=0 -> port 0 only.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_data/resp_valid stable, req_ready stays 0; release -> IDLE next cycle.
REQ-039 Assert rst during EXEC -> next cycle all outputs 0, FSM in IDLE, no response ever emitted for the aborted request.
